sm83_alu_nibble_seq: RTL
========================

// Module: sm83_alu_nibble_seq
// PURPOSE
//  Nibble-serial SM83 ALU sequencer: runs one 8-bit ALU/DAA/CB-shift op as two 4-bit passes (low, high).
//  Produces Z/N/H/C values plus write strobes for the flags register, consuming current C/H/N from it.
//  Sits between decode/control (start, op, operands) and the flags register; the register file takes the result.
// PARAMETERS
//  WORD_SIZE  8  datapath width; must be 8 (nibble = WORD_SIZE/2); any other value is a $error at elaboration
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  reset_n      in   1   asynchronous, active-low reset
//  start        in   1   launch op; accepted only while busy=0
//  op           in   5   sm83_alu_pkg::alu_op_t, sampled with start
//  a, b         in   8   operands, sampled with start
//  carry_flag   in   1   current C from flags register, sampled with start
//  half_flag    in   1   current H, sampled with start (DAA)
//  neg_flag     in   1   current N, sampled with start (DAA)
//  busy         out  1   op in flight (states LO, HI)
//  done         out  1   one-cycle pulse: result and final flags valid
//  result       out  8   op result; held until next done
//  result_we    out  1   with done: write result (0 for CP and NOP)
//  zero_out     out  1   Z value, valid with zero_we
//  neg_out      out  1   N value, valid with neg_we
//  half_out     out  1   H value, valid with half_we
//  carry_out    out  1   C value: adder carry/borrow, shift-out bit or DAA carry; valid with carry_we
//  zero_we, neg_we, carry_we  out  1 each   pulse with done when the op updates that flag
//  half_we      out  1   pulse in HI cycle (H known after low pass)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, result 0.
//  FSM: IDLE -start-> LO -> HI -> IDLE. start sampled at edge k: LO in cycle k+1, HI in k+2,
//   done pulse in k+3 (back in IDLE). start with done=1 is accepted (1 op per 3 cycles). start while busy: ignored.
//  LO: low nibble op, low carry registered. HI: high nibble with low carry chained in; half_we/half_out driven.
//  Ops: ADD 0, ADC 1, SUB 2, SBC 3, AND 4, XOR 5, OR 6, CP 7, DAA 8, RLC 9, RL 10, RRC 11, RR 12,
//   SLA 13, SRA 14, SRL 15, SWAP 16; 17..31 = NOP.
//  Arith: cin = 0 ADD, carry_flag ADC; SUB/CP/SBC add ~b with cin 1 / 1 / ~carry_flag.
//   Subtract flags hold borrow = inverted adder carry; N=1 for SUB/SBC/CP, else 0.
//  Logic: AND H=1,C=0; XOR/OR H=0,C=0; N=0. Z = (result==0) for all ops except NOP.
//  CP: flags as SUB, result_we=0, result=a.
//  DAA: uses sampled N/H/C; low pass +/-6 if H or (!N and lo>9); high pass +/-0x60 if C or (!N and a>0x99).
//   C = new carry; H=0; neg_we=0.
//  Shifts (CB): C = bit shifted out; H=0, N=0; RL/RR rotate carry_flag in; SRA keeps bit7.
//  NOP: done and result=a only; no flag strobes, result_we=0.
//  Reset asserted mid-op: immediate IDLE, no done, no strobes; a later start runs normally.
//  Operands/flags are latched at start; input changes while busy have no effect.
// CONFIGURATION
//  SM83_ALU_SWAP_EN defined: op 16 = SWAP (nibbles exchanged; Z from result; N=H=C=0, all four strobes).
//  Not defined: op 16 decodes as NOP; SWAP logic absent from netlist.
// STRUCTURE
//  Package sm83_alu_pkg: alu_op_t enum (values above), state_t {IDLE,LO,HI}, DAA_LO_ADJ=4'h6,
//   DAA_HI_ADJ=8'h60, flag bit index localparams Z=7/N=6/H=5/C=4.
//  Sub-module sm83_alu_nibble: combinational 4-bit add/logic slice (a4, b4, cin, op class -> r4, cout);
//   instantiated once and time-shared across LO/HI.
// TESTING
//  ADD a=0x3A b=0xC6 -> done 3 cycles after start; result 0x00, Z=1 N=0 H=1 C=1; half_we in HI cycle.
//  SUB a=0x10 b=0x01 -> result 0x0F, Z=0 N=1 H=1 C=0; CP same operands -> same flags, result_we=0.
//  ADC a=0xFF b=0x00 carry_flag=1 -> result 0x00, Z=1 H=1 C=1.
//  DAA a=0x3C, N=H=C=0 -> 0x42, C=0 H=0, neg_we=0; DAA a=0x9A, N=0 -> 0x00, Z=1 C=1.
//  RR a=0x01 carry_flag=0 -> 0x00, Z=1 C=1; start while busy ignored; back-to-back start on done accepted.
//  reset_n low during LO -> busy=0, no done/strobes; SWAP a=0xF1 -> 0x1F (EN) or 0xF1, no strobes (not EN).

Source files
------------

// File: rtl/sm83_alu_pkg.sv
// sm83_alu_pkg: op codes, FSM states, nibble-slice op classes and DAA/flag constants for the nibble-serial SM83 ALU
package sm83_alu_pkg;
    typedef enum logic [4:0] {
        OP_ADD = 5'd0, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_XOR, OP_OR, OP_CP,
        OP_DAA, OP_RLC, OP_RL, OP_RRC, OP_RR, OP_SLA, OP_SRA, OP_SRL, OP_SWAP
    } alu_op_t;
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;
    typedef enum logic [1:0] {CLS_ADD, CLS_AND, CLS_XOR, CLS_OR} nib_cls_t;
    localparam logic [3:0] DAA_LO_ADJ = 4'h6;
    localparam logic [7:0] DAA_HI_ADJ = 8'h60;
    localparam int Z = 7;
    localparam int N = 6;
    localparam int H = 5;
    localparam int C = 4;
endpackage

// File: rtl/sm83_alu_nibble.sv
// sm83_alu_nibble: combinational 4-bit add/logic slice, time-shared between the low and high passes
module sm83_alu_nibble
    import sm83_alu_pkg::*;
(
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       cin,
    input  nib_cls_t   cls,
    output logic [3:0] r4,
    output logic       cout
);
    logic [4:0] w_sum;
    // adder result or bitwise op; carry only meaningful for the adder class
    always_comb begin
        w_sum = {1'b0, a4} + {1'b0, b4} + {4'b0, cin};
        r4 = cls == CLS_ADD ? w_sum[3:0] : cls == CLS_AND ? a4 & b4 : cls == CLS_XOR ? a4 ^ b4 : a4 | b4;
        cout = cls == CLS_ADD && w_sum[4];
    end
endmodule

// File: rtl/sm83_alu_nibble_seq.sv
// sm83_alu_nibble_seq: runs one SM83 ALU/DAA/CB-shift op as low then high nibble pass; SM83_ALU_SWAP_EN enables op 16 = SWAP
module sm83_alu_nibble_seq
    import sm83_alu_pkg::*;
#(
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [4:0]           op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic                 carry_flag,
    input  logic                 half_flag,
    input  logic                 neg_flag,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] result,
    output logic                 result_we,
    output logic                 zero_out,
    output logic                 neg_out,
    output logic                 half_out,
    output logic                 carry_out,
    output logic                 zero_we,
    output logic                 neg_we,
    output logic                 half_we,
    output logic                 carry_we
);
    if (WORD_SIZE != 8) begin : g_bad_width
        $error("sm83_alu_nibble_seq: WORD_SIZE must be 8");
    end

    state_t     r_state, w_next;
    logic [4:0] r_op;
    logic [7:0] r_a, r_b;
    logic       r_c, r_h, r_n, r_cy;
    logic [3:0] r_lo;
    logic       w_sub, w_logic, w_daa, w_shift, w_swap, w_nop;
    logic       w_lo_adj, w_hi_adj, w_cin0, w_cin, w_cout, w_sh_co, w_hi_c, w_half;
    logic [7:0] w_adj, w_bop, w_alu, w_sh, w_val, w_res;
    logic [3:0] w_a4, w_b4, w_r4;
    logic [7:4] w_f;
    nib_cls_t   w_cls;

    // op decode and operand selection for the shared nibble slice; DAA reuses the adder with a +/- adjust operand
    always_comb begin
        w_sub = r_op inside {OP_SUB, OP_SBC, OP_CP};
        w_logic = r_op inside {OP_AND, OP_XOR, OP_OR};
        w_daa = r_op == OP_DAA;
        w_shift = r_op inside {OP_RLC, OP_RL, OP_RRC, OP_RR, OP_SLA, OP_SRA, OP_SRL};
`ifdef SM83_ALU_SWAP_EN
        w_swap = r_op == OP_SWAP;
`else
        w_swap = 1'b0;
`endif
        w_nop = r_op > OP_SRL && !w_swap;
        w_lo_adj = r_h || (!r_n && r_a[3:0] > 4'd9);
        w_hi_adj = r_c || (!r_n && r_a > 8'h99);
        w_adj = (w_hi_adj ? DAA_HI_ADJ : 8'h00) | (w_lo_adj ? {4'h0, DAA_LO_ADJ} : 8'h00);
        w_bop = w_daa ? (r_n ? ~w_adj : w_adj) : (w_sub ? ~r_b : r_b);
        w_cin0 = r_op == OP_ADC ? r_c : r_op == OP_SBC ? !r_c : r_op inside {OP_SUB, OP_CP} ? 1'b1 : w_daa && r_n;
        w_cls = r_op == OP_AND ? CLS_AND : r_op == OP_XOR ? CLS_XOR : r_op == OP_OR ? CLS_OR : CLS_ADD;
        w_a4 = r_state == HI ? r_a[7:4] : r_a[3:0];
        w_b4 = r_state == HI ? w_bop[7:4] : w_bop[3:0];
        w_cin = r_state == HI ? r_cy : w_cin0;
    end

    sm83_alu_nibble u_nibble (
        .a4   (w_a4),
        .b4   (w_b4),
        .cin  (w_cin),
        .cls  (w_cls),
        .r4   (w_r4),
        .cout (w_cout)
    );

    // CB shifts/rotates on the latched operand; sh_co is the bit pushed out
    always_comb begin
        w_sh = r_a;
        w_sh_co = 1'b0;
        case (r_op)
            OP_RLC:  {w_sh_co, w_sh} = {r_a[7], r_a[6:0], r_a[7]};
            OP_RL:   {w_sh_co, w_sh} = {r_a, r_c};
            OP_RRC:  {w_sh, w_sh_co} = {r_a[0], r_a[7:1], r_a[0]};
            OP_RR:   {w_sh, w_sh_co} = {r_c, r_a};
            OP_SLA:  {w_sh_co, w_sh} = {r_a, 1'b0};
            OP_SRA:  {w_sh, w_sh_co} = {r_a[7], r_a};
            OP_SRL:  {w_sh, w_sh_co} = {1'b0, r_a};
`ifdef SM83_ALU_SWAP_EN
            OP_SWAP: w_sh = {r_a[3:0], r_a[7:4]};
`endif
            default: ;
        endcase
    end

    // final result and flag values, valid in the HI cycle; subtract-type carries become borrows
    always_comb begin
        w_alu = {w_r4, r_lo};
        w_val = (w_shift || w_swap) ? w_sh : w_alu;
        w_res = (r_op == OP_CP || w_nop) ? r_a : w_val;
        w_hi_c = w_daa ? w_hi_adj : w_logic ? 1'b0 : (w_shift || w_swap) ? w_sh_co : w_sub ? !w_cout : w_cout;
        w_half = r_op == OP_AND ? 1'b1 : (w_logic || w_daa || w_shift || w_swap) ? 1'b0 : w_sub ? !r_cy : r_cy;
        w_f = '0;
        w_f[Z] = w_val == 8'h00;
        w_f[N] = w_sub;
        w_f[H] = w_half;
        w_f[C] = w_hi_c;
        w_next = r_state == IDLE ? (start ? LO : IDLE) : r_state == LO ? HI : IDLE;
        busy = r_state != IDLE;
        half_we = r_state == HI && !w_nop;
        half_out = half_we && w_f[H];
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    // operand latch at start, low-pass capture, and done/strobe/result registers at end of HI
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op <= '0;
            r_a <= '0;
            r_b <= '0;
            r_c <= 1'b0;
            r_h <= 1'b0;
            r_n <= 1'b0;
            r_lo <= '0;
            r_cy <= 1'b0;
            done <= 1'b0;
            result <= '0;
            result_we <= 1'b0;
            zero_we <= 1'b0;
            neg_we <= 1'b0;
            carry_we <= 1'b0;
            zero_out <= 1'b0;
            neg_out <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            done <= r_state == HI;
            result_we <= r_state == HI && !w_nop && r_op != OP_CP;
            zero_we <= r_state == HI && !w_nop;
            neg_we <= r_state == HI && !w_nop && !w_daa;
            carry_we <= r_state == HI && !w_nop;
            if (r_state == IDLE && start) begin
                r_op <= op;
                r_a <= a;
                r_b <= b;
                r_c <= carry_flag;
                r_h <= half_flag;
                r_n <= neg_flag;
            end
            if (r_state == LO) begin
                r_lo <= w_r4;
                r_cy <= w_cout;
            end
            if (r_state == HI) begin
                result <= w_res;
                zero_out <= w_f[Z];
                neg_out <= w_f[N];
                carry_out <= w_f[C];
            end
        end
    end
endmodule
